// File: rtl/aes_block_ctrl_if.sv
// Job/result stream bundle between the command FIFO side (master) and the
// AES block controller (slave). Input jobs and output results each use a
// valid/ready handshake.
interface aes_block_ctrl_if #(
  parameter int BLK_S = 128
);
  logic             in_valid;
  logic             in_ready;
  logic             in_decrypt;
  logic             in_key256;
  logic [BLK_S-1:0] in_block;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_S-1:0] out_block;
  logic             out_decrypt;

  modport master (
    output in_valid, in_decrypt, in_key256, in_block, out_ready,
    input  in_ready, out_valid, out_block, out_decrypt
  );

  modport slave (
    input  in_valid, in_decrypt, in_key256, in_block, out_ready,
    output in_ready, out_valid, out_block, out_decrypt
  );
endinterface

// File: rtl/aes_block_ctrl.sv
// AES block controller: accepts one encrypt/decrypt job at a time, kicks the
// cipher or decipher core, muxes the active core's round-key index onto the
// shared round-key SRAM read port and holds the result until taken.
// Optional watchdog: define AES_CTRL_TIMEOUT_EN to abort a job whose core
// never signals completion (err pulses, no result is produced).
//
// state | meaning
// IDLE  | waiting for a job; in_ready = !key_busy
// START | one-cycle enable pulse to the selected core
// RUN   | core iterating rounds; waiting for its en_o
// DONE  | result held on the output until out_ready
module aes_block_ctrl #(
  parameter int BLK_S    = 128,
  parameter int KEY_NO_W = 4
`ifdef AES_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 31
`endif
) (
  input  logic                clk,
  input  logic                reset,
  aes_block_ctrl_if.slave     bus,
  input  logic                key_busy,
  output logic                err,
  output logic                c_en,
  output logic [KEY_NO_W-1:0] c_rounds_total,
  output logic [BLK_S-1:0]    c_plaintext,
  input  logic [BLK_S-1:0]    c_ciphertext,
  input  logic [KEY_NO_W-1:0] c_round_key_no,
  input  logic                c_en_o,
  output logic                d_en,
  output logic [KEY_NO_W-1:0] d_rounds_total,
  output logic [BLK_S-1:0]    d_ciphertext,
  input  logic [BLK_S-1:0]    d_plaintext,
  input  logic [KEY_NO_W-1:0] d_round_key_no,
  input  logic                d_en_o,
  output logic [KEY_NO_W:0]   key_sram_addr,
  input  logic [BLK_S-1:0]    key_sram_rdata,
  output logic [BLK_S-1:0]    round_key
);

  localparam logic [KEY_NO_W-1:0] NR_128 = KEY_NO_W'(10);
  localparam logic [KEY_NO_W-1:0] NR_256 = KEY_NO_W'(14);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t             state;
  logic               op_q;
  logic               key256_q;
  logic               out_valid_q;
  logic [BLK_S-1:0]   out_block_q;
  logic               out_decrypt_q;
  logic               in_ready_w;
  logic               sel_en_o;
  logic [BLK_S-1:0]   sel_out;
  logic [KEY_NO_W-1:0] nr_sel;

  // Acceptance is combinational so a key_busy drop can be taken the same cycle.
  assign in_ready_w = (state == IDLE) && !key_busy && !reset;
  assign sel_en_o   = op_q ? d_en_o : c_en_o;
  assign sel_out    = op_q ? d_plaintext : c_ciphertext;
  assign nr_sel     = bus.in_key256 ? NR_256 : NR_128;

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_block   = out_block_q;
  assign bus.out_decrypt = out_decrypt_q;

  // The SRAM port always follows the core chosen by the latched operation.
  assign key_sram_addr = {key256_q, op_q ? d_round_key_no : c_round_key_no};
  assign round_key     = key_sram_rdata;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYCLES - 1);
  logic [4:0] tmo_cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Job sequencer with registered core enables and result hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= 1'b0;
      key256_q       <= 1'b0;
      c_en           <= 1'b0;
      d_en           <= 1'b0;
      c_rounds_total <= '0;
      d_rounds_total <= '0;
      c_plaintext    <= '0;
      d_ciphertext   <= '0;
      out_valid_q    <= 1'b0;
      out_block_q    <= '0;
      out_decrypt_q  <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
      tmo_cnt        <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      c_en <= 1'b0;
      d_en <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_w) begin
            op_q     <= bus.in_decrypt;
            key256_q <= bus.in_key256;
            if (bus.in_decrypt) begin
              d_en           <= 1'b1;
              d_ciphertext   <= bus.in_block;
              d_rounds_total <= nr_sel;
            end else begin
              c_en           <= 1'b1;
              c_plaintext    <= bus.in_block;
              c_rounds_total <= nr_sel;
            end
            state <= START;
          end
        end
        START: begin
`ifdef AES_CTRL_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          if (sel_en_o) begin
            out_block_q   <= sel_out;
            out_decrypt_q <= op_q;
            out_valid_q   <= 1'b1;
            state         <= DONE;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 5'd1;
          end
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Bench for aes_block_ctrl: behavioural cipher/decipher stubs, a 1-cycle
// round-key SRAM, a result scoreboard and a table of jobs, plus sequences for
// reset mid-job and (with AES_CTRL_TIMEOUT_EN) the watchdog abort.
module tb_aes_block_ctrl;
  localparam int BLK_S = 128;
  localparam int KW    = 4;
  localparam logic [127:0] PT    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] CT256 = 128'h8960494b9049fceabf456751cab7a28e;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_busy = 1'b0;
  logic err;
  logic c_en, d_en;
  logic [KW-1:0] c_rounds_total, d_rounds_total;
  logic [127:0] c_plaintext, d_ciphertext;
  logic [127:0] c_ciphertext = '0, d_plaintext = '0;
  logic [KW-1:0] c_round_key_no = '0, d_round_key_no = '0;
  logic c_en_o = 1'b0, d_en_o = 1'b0;
  logic [KW:0] key_sram_addr;
  logic [127:0] key_sram_rdata = '0;
  logic [127:0] round_key;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_block_ctrl_if #(.BLK_S(BLK_S)) job_if ();

  aes_block_ctrl #(.BLK_S(BLK_S), .KEY_NO_W(KW)) dut (
    .clk(clk), .reset(reset), .bus(job_if), .key_busy(key_busy), .err(err),
    .c_en(c_en), .c_rounds_total(c_rounds_total), .c_plaintext(c_plaintext),
    .c_ciphertext(c_ciphertext), .c_round_key_no(c_round_key_no), .c_en_o(c_en_o),
    .d_en(d_en), .d_rounds_total(d_rounds_total), .d_ciphertext(d_ciphertext),
    .d_plaintext(d_plaintext), .d_round_key_no(d_round_key_no), .d_en_o(d_en_o),
    .key_sram_addr(key_sram_addr), .key_sram_rdata(key_sram_rdata), .round_key(round_key)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, event not seen (cycle %0d)", name, cyc);
  endtask

  // Known AES vectors, otherwise a simple reversible stand-in transform.
  function automatic logic [127:0] core_ref(input logic dec, input logic k256, input logic [127:0] b);
    if (dec && !k256 && b == CT128) return PT;
    if (dec && k256 && b == CT256) return PT;
    if (!dec && !k256 && b == PT) return CT128;
    return {b[63:0], b[127:64]} ^ {126'd0, k256, dec};
  endfunction

  // Core stubs: en starts a run of nr+1 cycles with round_key_no counting up;
  // an idle core emits stray en_o pulses with junk data.
  logic stall = 1'b0;
  logic c_busy = 1'b0, d_busy = 1'b0;
  int c_cnt = 0, d_cnt = 0;
  logic [127:0] c_in = '0, d_in = '0;
  logic [KW-1:0] c_nr = '0, d_nr = '0;
  int c_done_cyc = -10, d_done_cyc = -10;

  always @(posedge clk) begin
    c_en_o <= 1'b0;
    if (reset) begin
      c_busy <= 1'b0;
      c_round_key_no <= '0;
    end else if (c_en) begin
      c_busy <= 1'b1; c_cnt <= 0; c_round_key_no <= '0;
      c_in <= c_plaintext; c_nr <= c_rounds_total;
    end else if (c_busy) begin
      if (c_cnt == int'(c_nr)) begin
        if (!stall) begin
          c_en_o <= 1'b1;
          c_ciphertext <= core_ref(1'b0, c_nr == 4'd14, c_in);
          c_busy <= 1'b0;
          c_done_cyc <= cyc + 1;
        end
      end else begin
        c_cnt <= c_cnt + 1;
        c_round_key_no <= c_round_key_no + 1'b1;
      end
    end else if (cyc % 4 == 1) begin
      c_en_o <= 1'b1;
      c_ciphertext <= {4{32'hdeadbeef}};
    end
  end

  always @(posedge clk) begin
    d_en_o <= 1'b0;
    if (reset) begin
      d_busy <= 1'b0;
      d_round_key_no <= '0;
    end else if (d_en) begin
      d_busy <= 1'b1; d_cnt <= 0; d_round_key_no <= '0;
      d_in <= d_ciphertext; d_nr <= d_rounds_total;
    end else if (d_busy) begin
      if (d_cnt == int'(d_nr)) begin
        if (!stall) begin
          d_en_o <= 1'b1;
          d_plaintext <= core_ref(1'b1, d_nr == 4'd14, d_in);
          d_busy <= 1'b0;
          d_done_cyc <= cyc + 1;
        end
      end else begin
        d_cnt <= d_cnt + 1;
        d_round_key_no <= d_round_key_no + 1'b1;
      end
    end else if (cyc % 4 == 3) begin
      d_en_o <= 1'b1;
      d_plaintext <= {4{32'hbadc0ffe}};
    end
  end

  always @(posedge clk) key_sram_rdata <= {4{27'h5a5a5a5, key_sram_addr}};

  // Scoreboard and per-cycle monitor.
  typedef struct {logic [127:0] blk; logic dec;} sb_t;
  sb_t sbq[$];
  logic [127:0] cur_exp = '0;
  logic job_dec = 1'b0, job_k256 = 1'b0, in_job = 1'b0, prev_ov = 1'b0;
  logic [127:0] held_blk = '0;
  logic held_dec = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      sb_t e;
      chk("round_key_passthru", round_key, key_sram_rdata);
`ifndef AES_CTRL_TIMEOUT_EN
      chk("err_tied_low", err, 1'b0);
`endif
      if (in_job) begin
        chk("key_sram_addr", key_sram_addr,
            {job_k256, job_dec ? d_round_key_no : c_round_key_no});
        chk("unselected_en_low", job_dec ? c_en : d_en, 1'b0);
      end
      if (sbq.size() == 0) chk("out_valid_without_job", job_if.out_valid, 1'b0);
      if (job_if.out_valid) begin
        if (!prev_ov) begin
          chk("out_valid_latency", cyc, (job_dec ? d_done_cyc : c_done_cyc) + 1);
          held_blk = job_if.out_block;
          held_dec = job_if.out_decrypt;
        end else begin
          chk("out_block_stable", job_if.out_block, held_blk);
          chk("out_decrypt_stable", job_if.out_decrypt, held_dec);
        end
        if (job_if.out_ready && sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_block", job_if.out_block, e.blk);
          chk("out_decrypt", job_if.out_decrypt, e.dec);
          in_job = 1'b0;
        end
      end
      if (job_if.in_valid && job_if.in_ready) begin
        sbq.push_back('{cur_exp, job_if.in_decrypt});
        job_dec  = job_if.in_decrypt;
        job_k256 = job_if.in_key256;
        in_job   = 1'b1;
      end
      prev_ov = job_if.out_valid;
    end
  end

  // Drive a job. hold < 0: out_ready held high; else out_ready low for hold
  // cycles of out_valid. busy_pre: cycles of key_busy with in_valid before accept.
  task automatic run_job(input logic dec, input logic k256, input logic [127:0] blk,
                         input logic [127:0] exp, input int hold, input int busy_pre,
                         input bit busy_mid);
    int n;
    @(posedge clk); #1;
    cur_exp = exp;
    job_if.in_decrypt = dec;
    job_if.in_key256  = k256;
    job_if.in_valid   = 1'b1;
    job_if.out_ready  = (hold < 0);
    if (busy_pre > 0) begin
      key_busy = 1'b1;
      for (int i = 0; i < busy_pre; i++) begin
        job_if.in_block = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("in_ready_while_key_busy", job_if.in_ready, 1'b0);
        @(posedge clk); #1;
      end
      key_busy = 1'b0;
    end
    job_if.in_block = blk;
    @(negedge clk);
    if (busy_pre > 0) chk("accept_on_key_busy_drop", job_if.in_ready, 1'b1);
    n = 0;
    while (!job_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!job_if.in_ready) begin
      fail_bound("accept_wait");
      job_if.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    job_if.in_valid = 1'b0;
    job_if.in_block = {$urandom, $urandom, $urandom, $urandom};
    if (busy_mid) key_busy = 1'b1;
    @(negedge clk);
    chk("start_c_en", c_en, !dec);
    chk("start_d_en", d_en, dec);
    chk("start_in_ready_low", job_if.in_ready, 1'b0);
    if (dec) begin
      chk("d_rounds_total", d_rounds_total, k256 ? 4'd14 : 4'd10);
      chk("d_ciphertext", d_ciphertext, blk);
    end else begin
      chk("c_rounds_total", c_rounds_total, k256 ? 4'd14 : 4'd10);
      chk("c_plaintext", c_plaintext, blk);
    end
    @(negedge clk);
    chk("en_single_cycle", {c_en, d_en}, 2'b00);
    n = 0;
    while (!job_if.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!job_if.out_valid) begin
      fail_bound("out_valid_wait");
      key_busy = 1'b0;
      return;
    end
    key_busy = 1'b0;
    if (hold < 0) begin
      @(negedge clk);
      chk("one_cycle_handshake_out_valid", job_if.out_valid, 1'b0);
      chk("in_ready_after_handshake", job_if.in_ready, 1'b1);
    end else begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_out_valid", job_if.out_valid, 1'b1);
        chk("hold_in_ready_low", job_if.in_ready, 1'b0);
      end
      @(posedge clk); #1;
      job_if.out_ready = 1'b1;
      @(posedge clk); #1;
      job_if.out_ready = 1'b0;
      @(negedge clk);
      chk("out_valid_after_handshake", job_if.out_valid, 1'b0);
      chk("in_ready_after_handshake", job_if.in_ready, 1'b1);
    end
  endtask

  typedef struct {
    logic dec; logic k256; logic [127:0] blk; logic [127:0] exp;
    int hold; int busy_pre; bit busy_mid;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    logic [127:0] x1, x2, x3, x4;
    x1 = 128'h0123456789abcdeffedcba9876543210;
    x2 = 128'hfedcba98765432100123456789abcdef;
    x3 = 128'h00112233445566778899aabbccddeeff;
    x4 = 128'hdeadbeefcafef00d0badf00d12345678;
    tbl[0] = '{1'b1, 1'b0, CT128, PT,    0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, CT256, PT,    2, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, PT,    CT128, -1, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, x1, core_ref(1'b0, 1'b0, x1), 20, 0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, x2, core_ref(1'b1, 1'b0, x2), -1, 5, 1'b0};
    tbl[5] = '{1'b0, 1'b1, x3, core_ref(1'b0, 1'b1, x3), 1, 0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, x4, core_ref(1'b1, 1'b1, x4), 0, 0, 1'b0};

    job_if.in_valid = 1'b1;
    job_if.in_decrypt = 1'b0;
    job_if.in_key256 = 1'b0;
    job_if.in_block = '0;
    job_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready_forced_low", job_if.in_ready, 1'b0);
    chk("reset_out_valid", job_if.out_valid, 1'b0);
    chk("reset_en", {c_en, d_en}, 2'b00);
    chk("reset_err", err, 1'b0);
    chk("reset_out_block", job_if.out_block, '0);
    chk("reset_out_decrypt", job_if.out_decrypt, 1'b0);
    chk("reset_rounds_total", {c_rounds_total, d_rounds_total}, '0);
    chk("reset_c_plaintext", c_plaintext, '0);
    chk("reset_d_ciphertext", d_ciphertext, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    job_if.in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", job_if.in_ready, 1'b1);

    for (int i = 0; i < 7; i++)
      run_job(tbl[i].dec, tbl[i].k256, tbl[i].blk, tbl[i].exp,
              tbl[i].hold, tbl[i].busy_pre, tbl[i].busy_mid);

    // Reset in RUN discards the job.
    stall = 1'b1;
    @(posedge clk); #1;
    cur_exp = 128'h1;
    job_if.in_decrypt = 1'b0;
    job_if.in_key256 = 1'b1;
    job_if.in_block = x3;
    job_if.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!job_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!job_if.in_ready) fail_bound("reset_test_accept");
    @(posedge clk); #1;
    job_if.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    sbq.delete();
    in_job = 1'b0;
    @(negedge clk);
    chk("midjob_reset_in_ready_low", job_if.in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midjob_reset_out_valid", job_if.out_valid, 1'b0);
    chk("midjob_reset_en", {c_en, d_en}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_midjob_reset", job_if.in_ready, 1'b1);
    repeat (20) begin
      @(negedge clk);
      chk("no_out_valid_after_reset", job_if.out_valid, 1'b0);
    end

    run_job(1'b1, 1'b0, CT128, PT, 0, 0, 1'b0);

`ifdef AES_CTRL_TIMEOUT_EN
    begin
      int s;
      stall = 1'b1;
      @(posedge clk); #1;
      cur_exp = 128'h2;
      job_if.in_decrypt = 1'b1;
      job_if.in_key256 = 1'b0;
      job_if.in_block = x1;
      job_if.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!job_if.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      job_if.in_valid = 1'b0;
      @(negedge clk);
      chk("tmo_start_d_en", d_en, 1'b1);
      s = cyc;
      n = 0;
      while (n < 60) begin
        @(negedge clk);
        if (err) break;
        chk("tmo_no_out_valid", job_if.out_valid, 1'b0);
        n++;
      end
      if (!err) fail_bound("tmo_err_wait");
      else begin
        chk("tmo_err_cycle", cyc - s, 32);
        chk("tmo_out_valid_low", job_if.out_valid, 1'b0);
        chk("tmo_in_ready_idle", job_if.in_ready, 1'b1);
        sbq.delete();
        in_job = 1'b0;
        @(negedge clk);
        chk("tmo_err_one_cycle", err, 1'b0);
      end
      stall = 1'b0;
    end
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
